// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small show-ahead byte FIFO, clocked by the 50 MHz board clock.
// Bytes with a bad stop bit are dropped; good bytes arriving into a full FIFO are dropped with an overrun pulse.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          physical_clock,
    input  logic                          n_reset,
    input  logic                          rx,
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic                          rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] STOP  = 3'd3;
    localparam logic [2:0] BRK   = 3'd4;

    logic          rx_meta;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic bit_end;
    logic pop;
    logic full;
    logic push;

    assign bit_end    = (clk_cnt == BIT_END);
    assign rx_valid   = (count != '0);
    assign pop        = rd_en && rx_valid;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept the byte.
    assign full       = (count == FULL_CNT) && !pop;
    assign push       = (state == STOP) && bit_end && rx_s && !full;
    assign busy       = (state != IDLE);
    assign fifo_count = count;
    assign rd_data    = rx_valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge physical_clock) begin
        if (!n_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge physical_clock) begin
        if (!n_reset) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state   <= START;
                        clk_cnt <= '0;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_END) begin
                        if (!rx_s) begin
                            state   <= DATA;
                            clk_cnt <= '0;
                            bit_idx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        shift[bit_idx] <= rx_s;
                        clk_cnt        <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            overrun <= full;
                            state   <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BRK;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                // Hold off until the line is released so a long break is not seen as new start bits.
                BRK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge physical_clock) begin
        if (n_reset && push) begin
            mem[wr_ptr] <= shift;
        end
    end

    always_ff @(posedge physical_clock) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed-plus-random bench for uart_rx_fifo; a byte queue models the FIFO contents and drop rules.
module tb_uart_rx_fifo;

    localparam int CPB   = 16;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;
    localparam int LAT   = 2 + CPB / 2 + 9 * CPB + 1;

    logic       physical_clock = 1'b0;
    logic       n_reset        = 1'b0;
    logic       rx             = 1'b1;
    logic       rd_en          = 1'b0;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [3:0] fifo_count;
    logic       busy;
    logic       frame_err;
    logic       overrun;

    int total     = 0;
    int bad       = 0;
    int fe_seen   = 0;
    int ov_seen   = 0;
    int busy_seen = 0;
    int exp_fe    = 0;
    int exp_ov    = 0;
    int rise_at   = -1;
    logic [7:0] model_q [$];

    uart_rx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .physical_clock(physical_clock),
        .n_reset       (n_reset),
        .rx            (rx),
        .rd_en         (rd_en),
        .rd_data       (rd_data),
        .rx_valid      (rx_valid),
        .fifo_count    (fifo_count),
        .busy          (busy),
        .frame_err     (frame_err),
        .overrun       (overrun)
    );

    always #5 physical_clock = ~physical_clock;

    // Every clock passes through here, so pulse widths are counted exactly.
    task automatic tick();
        @(posedge physical_clock);
        #1;
        if (frame_err) fe_seen++;
        if (overrun)   ov_seen++;
        if (busy)      busy_seen++;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Sends one frame; optionally pops in the stop-decision cycle or pulses reset at clock reset_at.
    task automatic applyStimulus(input logic [7:0] data, input logic stop_val,
                                 input bit pop_at_stop, input int reset_at);
        logic [9:0] frame;
        logic       prev;
        frame   = {stop_val, data, 1'b0};
        rise_at = -1;
        for (int i = 0; i < FRAME; i++) begin
            rx    = frame[i / CPB];
            rd_en = pop_at_stop && (i == LAT - 1);
            if (i == reset_at) n_reset = 1'b0;
            prev = rx_valid;
            tick();
            n_reset = 1'b1;
            rd_en   = 1'b0;
            if (!prev && rx_valid && rise_at < 0) rise_at = i + 1;
            if (i == reset_at) return;
        end
    endtask

    task automatic model_frame(input logic [7:0] data, input bit pop_at_stop);
        if (pop_at_stop && model_q.size() > 0) void'(model_q.pop_front());
        if (model_q.size() < DEPTH) model_q.push_back(data);
        else exp_ov++;
    endtask

    task automatic do_pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        if (model_q.size() > 0) void'(model_q.pop_front());
    endtask

    task automatic drain_check(input string tag);
        while (model_q.size() > 0) begin
            checkOutput({tag, "_valid"}, int'(rx_valid), 1);
            checkOutput({tag, "_data"}, int'(rd_data), int'(model_q[0]));
            do_pop();
        end
        checkOutput({tag, "_empty"}, int'(rx_valid), 0);
        checkOutput({tag, "_count"}, int'(fifo_count), 0);
    endtask

    initial begin
        logic [7:0] b;
        bit         ps;

        $display("[TB] reset");
        n_reset = 1'b0;
        rx      = 1'b1;
        tick();
        tick();
        checkOutput("rst_rd_data", int'(rd_data), 0);
        checkOutput("rst_rx_valid", int'(rx_valid), 0);
        checkOutput("rst_count", int'(fifo_count), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_frame_err", int'(frame_err), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        n_reset = 1'b1;
        repeat (4) tick();

        $display("[TB] single byte");
        applyStimulus(8'hA5, 1'b1, 1'b0, -1);
        model_frame(8'hA5, 1'b0);
        checkOutput("t1_latency_window", int'(rise_at >= LAT - 1 && rise_at <= LAT + 1), 1);
        checkOutput("t1_rd_data", int'(rd_data), 32'hA5);
        checkOutput("t1_count", int'(fifo_count), 1);
        do_pop();
        checkOutput("t1_valid_after_pop", int'(rx_valid), 0);
        checkOutput("t1_count_after_pop", int'(fifo_count), 0);
        do_pop();
        checkOutput("t1_pop_empty_count", int'(fifo_count), 0);

        $display("[TB] start glitch");
        busy_seen = 0;
        rx = 1'b0;
        repeat (4) tick();
        rx = 1'b1;
        repeat (CPB) tick();
        checkOutput("t2_busy_pulsed", int'(busy_seen != 0), 1);
        checkOutput("t2_busy_idle", int'(busy), 0);
        checkOutput("t2_count", int'(fifo_count), 0);
        checkOutput("t2_no_frame_err", fe_seen, exp_fe);

        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 1'b0, 1'b0, -1);
        exp_fe++;
        repeat (40) tick();
        checkOutput("t3_frame_err_pulses", fe_seen, exp_fe);
        checkOutput("t3_busy_in_break", int'(busy), 1);
        checkOutput("t3_count", int'(fifo_count), 0);
        rx = 1'b1;
        repeat (4) tick();
        checkOutput("t3_busy_released", int'(busy), 0);
        applyStimulus(8'h81, 1'b1, 1'b0, -1);
        model_frame(8'h81, 1'b0);
        checkOutput("t3_rd_data", int'(rd_data), 32'h81);
        drain_check("t3_drain");

        $display("[TB] back-to-back fill and overrun");
        for (int k = 0; k < 9; k++) begin
            applyStimulus(8'(k), 1'b1, 1'b0, -1);
            model_frame(8'(k), 1'b0);
            if (k == 7) checkOutput("t4_count_full", int'(fifo_count), DEPTH);
        end
        checkOutput("t4_overrun_pulses", ov_seen, exp_ov);
        checkOutput("t4_count_after_ovr", int'(fifo_count), int'(model_q.size()));
        drain_check("t4_drain");

        $display("[TB] pop during stop decision while full");
        for (int k = 0; k < DEPTH; k++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, 1'b0, -1);
            model_frame(b, 1'b0);
        end
        checkOutput("t5_count_full", int'(fifo_count), DEPTH);
        applyStimulus(8'h5A, 1'b1, 1'b1, -1);
        model_frame(8'h5A, 1'b1);
        checkOutput("t5_no_overrun", ov_seen, exp_ov);
        checkOutput("t5_count", int'(fifo_count), DEPTH);
        checkOutput("t5_model_tail", int'(model_q[DEPTH - 1]), 32'h5A);
        drain_check("t5_drain");

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            applyStimulus(b, 1'b1, 1'b0, -1);
            model_frame(b, 1'b0);
        end
        checkOutput("t6_count_before", int'(fifo_count), 3);
        applyStimulus(8'hFF, 1'b1, 1'b0, 5 * CPB);
        model_q.delete();
        checkOutput("t6_rd_data", int'(rd_data), 0);
        checkOutput("t6_rx_valid", int'(rx_valid), 0);
        checkOutput("t6_count", int'(fifo_count), 0);
        checkOutput("t6_busy", int'(busy), 0);
        checkOutput("t6_frame_err", int'(frame_err), 0);
        checkOutput("t6_overrun", int'(overrun), 0);
        rx = 1'b1;
        repeat (2 * CPB) tick();
        checkOutput("t6_no_stray_fe", fe_seen, exp_fe);
        applyStimulus(8'h42, 1'b1, 1'b0, -1);
        model_frame(8'h42, 1'b0);
        checkOutput("t6_rd_data_after", int'(rd_data), 32'h42);
        drain_check("t6_drain");

        $display("[TB] random traffic");
        for (int r = 0; r < 14; r++) begin
            b  = 8'($urandom);
            ps = ($urandom_range(0, 3) == 0);
            applyStimulus(b, 1'b1, ps, -1);
            model_frame(b, ps);
            checkOutput("rand_count", int'(fifo_count), int'(model_q.size()));
            if ($urandom_range(0, 2) == 0 && model_q.size() > 0) begin
                checkOutput("rand_head", int'(rd_data), int'(model_q[0]));
                do_pop();
            end
        end
        checkOutput("rand_overrun", ov_seen, exp_ov);
        checkOutput("rand_frame_err", fe_seen, exp_fe);
        drain_check("rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive end of the board's 8N1 serial link. It deserialises a `rx` line driven by a UART transmitter, either the other controller's `tx` or an external pin.
- Received bytes are buffered in a small show-ahead FIFO, so the CPU side (UART decoder/write-back path) can pop them at instruction rate without losing bytes.
- Runs on the 50 MHz board clock, not the scaled CPU clock.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200); minimum 4, must be even.
- FIFO_DEPTH, 8, byte entries; power of two, from 2 to 64.

Ports:
- physical_clock  in  1  50 MHz board clock; all logic on its rising edge.
- n_reset  in  1  synchronous active-low reset.
- rx  in  1  asynchronous serial input; idles high.
- rd_en  in  1  pop request; sampled each clock.
- rd_data  out  8  FIFO head byte; valid while rx_valid=1.
- rx_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
- busy  out  1  receiver is in a state other than IDLE.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled as 0.
- overrun  out  1  one-cycle pulse when a good byte arrives while the FIFO is full.

Behaviour:
- Reset: one clock with n_reset=0 clears everything.
  - FSM goes to IDLE; bit counter and clock counter go to 0.
  - FIFO pointers and count go to 0; rd_data=0, rx_valid=0, busy=0, frame_err=0, overrun=0.
  - Both synchroniser flops are set to 1.
  - Reset mid-frame abandons the frame; nothing is pushed and no error pulse is raised.
- Input sync: two-flop synchroniser; rx_s is rx delayed by 2 clocks. All FSM decisions use rx_s only.
- Sample point: the clock counter counts 0..CLKS_PER_BIT-1.
- FSM states:
  - IDLE: when rx_s=0, go to START and clear the counter.
  - START: at count CLKS_PER_BIT/2-1 (mid start bit), check rx_s.
    - rx_s=0: go to DATA with counter=0 and bit index=0.
    - rx_s=1: treat as a glitch and return to IDLE; no pulse.
  - DATA: at count CLKS_PER_BIT-1 (mid bit), shift rx_s into bit[index], LSB first, and wrap the counter to 0.
    - After index 7 go to STOP; otherwise increment the index.
  - STOP: at count CLKS_PER_BIT-1, check rx_s.
    - rx_s=1, FIFO not full: push the byte and go to IDLE.
    - rx_s=1, FIFO full: pulse overrun, drop the byte (FIFO contents unchanged), go to IDLE.
    - rx_s=0: pulse frame_err, discard the byte, go to BREAK.
  - BREAK: wait until rx_s=1, then go to IDLE. This prevents a held-low line from being taken as new start bits.
- busy=1 in START, DATA, STOP and BREAK.
- Error pulses are registered: each lasts exactly the one clock after the STOP decision.
- FIFO:
  - Show-ahead: rd_data is the head entry, combinationally from the registered array/pointer.
  - Push takes effect at the clock edge of the STOP decision. rx_valid, fifo_count and rd_data update on the next cycle.
  - Pop: rd_en=1 with rx_valid=1 advances the head at that edge. rd_en while empty is ignored and the count stays 0.
  - Simultaneous push and pop: both happen and the count is unchanged.
    - This applies even when full: the pop frees the slot, the push is accepted and there is no overrun.
    - Full is evaluated as count==FIFO_DEPTH && !(rd_en && rx_valid).
  - Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Count saturates at FIFO_DEPTH by construction.
- Latency: from the falling edge of the start bit on rx to rx_valid=1 is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks, ±1 for edge alignment.
- Back-to-back frames (stop bit directly followed by a start bit) are received without loss. The FSM is in IDLE about CLKS_PER_BIT/2 clocks before the next start edge.

Test Plan (CLKS_PER_BIT=16, FIFO_DEPTH=8):
1. Reset, then send 0xA5 with 16 clocks per bit → rx_valid rises 155±1 clocks after the start edge, rd_data=0xA5, fifo_count=1. Pulse rd_en once → rx_valid=0, count=0.
2. Drive rx low for 4 clocks, then high → busy pulses, FSM returns to IDLE, no byte, no frame_err; count stays 0.
3. Send 0x3C with the stop bit forced to 0, holding rx low for 40 more clocks → one frame_err pulse, count=0, busy=1 until rx returns high. Then send 0x81 → received correctly as 0x81.
4. Send 0x00..0x08 back-to-back with no reads → count=8 after the 8th byte, exactly one overrun pulse at the 9th stop bit. Eight pops then return 0x00..0x07 in order.
5. With the FIFO full, assert rd_en in the STOP-decision cycle of a 0x5A frame → no overrun, count stays 8, and 0x5A is the last of the eight entries.
6. Assert n_reset=0 for 1 clock midway through the DATA bits of 0xFF with count=3 → next cycle all outputs are 0 and count=0. The following 0x42 frame is received correctly.
